// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding and a ceiling-log2 helper used to size the bit counter.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Controller <-> serial_sub handshake and result bus.
// Optional SERIAL_SUB_ADDMODE_EN adds the add/subtract mode select.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_ADDMODE_EN
  logic             mode;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

`ifdef SERIAL_SUB_ADDMODE_EN
  modport master (output start, a, b, mode, input busy, done, diff, bout, zero);
  modport slave  (input start, a, b, mode, output busy, done, diff, bout, zero);
`else
  modport master (output start, a, b, input busy, done, diff, bout, zero);
  modport slave  (input start, a, b, output busy, done, diff, bout, zero);
`endif
endinterface

// File: rtl/serial_sub_full_sub_bit.sv
// One-bit full subtractor cell (combinational).
// With SERIAL_SUB_ADDMODE_EN, mode=1 turns it into a full adder and bo
// becomes the carry-out.
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
`ifdef SERIAL_SUB_ADDMODE_EN
  input  logic mode,
`endif
  output logic d,
  output logic bo
);

  // Sum/difference bit is the same for add and subtract; only the
  // borrow/carry term differs.
  always_comb begin
    d = a ^ b ^ bin;
`ifdef SERIAL_SUB_ADDMODE_EN
    if (mode) bo = (a & b) | ((a ^ b) & bin);
    else      bo = (~a & b) | (~(a ^ b) & bin);
`else
    bo = (~a & b) | (~(a ^ b) & bin);
`endif
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full_sub_bit cell reused over WIDTH cycles,
// LSB first, with a borrow flip-flop between bits.
// Optional macro SERIAL_SUB_ADDMODE_EN adds bus.mode (1 = add).
module serial_sub
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_sub_if.slave bus
);

  localparam int unsigned CW = (clog2(WIDTH) == 0) ? 1 : clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, w_q, w_d;
  logic [WIDTH-1:0] diff_q;
  logic             br_q, bout_q, zero_q;
  logic [CW-1:0]    cnt_q;
  logic             last;
  logic             cell_d, cell_bo;
`ifdef SERIAL_SUB_ADDMODE_EN
  logic             mode_q;
`endif

  full_sub_bit u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
`ifdef SERIAL_SUB_ADDMODE_EN
    .mode (mode_q),
`endif
    .d    (cell_d),
    .bo   (cell_bo)
  );

  // Working word with the new bit entering at the MSB; last-bit detect.
  always_comb begin
    w_d  = (w_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
    last = (cnt_q == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand load, per-bit shift, result capture on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      w_q    <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
`ifdef SERIAL_SUB_ADDMODE_EN
      mode_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            br_q  <= 1'b0;
            cnt_q <= '0;
`ifdef SERIAL_SUB_ADDMODE_EN
            mode_q <= bus.mode;
`endif
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          w_q   <= w_d;
          br_q  <= cell_bo;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            diff_q <= w_d;
            bout_q <= cell_bo;
            zero_q <= (w_d == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: all driven from registers only.
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.diff = diff_q;
    bus.bout = bout_q;
    bus.zero = zero_q;
  end

endmodule

// File: tb/tb_serial_sub.sv
`timescale 1ns/1ps
module tb_serial_sub;

  localparam int unsigned W8 = 8;
  localparam int unsigned W1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(W8)) if8 ();
  serial_sub_if #(.WIDTH(W1)) if1 ();

  serial_sub #(.WIDTH(W8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_sub #(.WIDTH(W1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_checks = 0;
  int n_fail   = 0;

  // Last completed result per DUT (index 0 = 8-bit, 1 = 1-bit).
  logic [31:0] prev_diff [2];
  logic        prev_bout [2];
  logic        prev_zero [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the operand values.
  task automatic model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                       input bit md, output logic [31:0] d, output logic bo);
    longint unsigned m, av, bv, r;
    m  = (64'd1 << w) - 1;
    av = 64'(a) & m;
    bv = 64'(b) & m;
    if (md) begin
      r  = av + bv;
      bo = (r > m);
    end else begin
      r  = av - bv;
      bo = (av < bv);
    end
    d = 32'(r & m);
  endtask

  function automatic int unsigned width_of(input bit w1);
    return w1 ? W1 : W8;
  endfunction

  task automatic drive(input bit w1, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (w1) begin
      if1.start = s; if1.a = a[0:0]; if1.b = b[0:0];
    end else begin
      if8.start = s; if8.a = a[7:0]; if8.b = b[7:0];
    end
  endtask

  function automatic logic [31:0] get_diff(input bit w1);
    return w1 ? 32'(if1.diff) : 32'(if8.diff);
  endfunction
  function automatic logic get_busy(input bit w1); return w1 ? if1.busy : if8.busy; endfunction
  function automatic logic get_done(input bit w1); return w1 ? if1.done : if8.done; endfunction
  function automatic logic get_bout(input bit w1); return w1 ? if1.bout : if8.bout; endfunction
  function automatic logic get_zero(input bit w1); return w1 ? if1.zero : if8.zero; endfunction

  // One full transaction starting at a negedge with the DUT idle; ends
  // at a negedge with the DUT idle again.
  task automatic run_op(input bit w1, input logic [31:0] a, input logic [31:0] b, input bit md);
    int unsigned w;
    int          i;
    logic [31:0] ed;
    logic        eb;
    w = width_of(w1);
    i = w1 ? 1 : 0;
    model(w, a, b, md, ed, eb);
    drive(w1, 1'b1, a, b);
`ifdef SERIAL_SUB_ADDMODE_EN
    if (w1) if1.mode = md; else if8.mode = md;
`endif
    @(posedge clk); #1;
    drive(w1, 1'b0, $urandom, $urandom);
    for (int k = 1; k <= int'(w); k++) begin
      @(negedge clk);
      check($sformatf("busy w%0d k%0d", w, k), get_busy(w1), 1);
      check($sformatf("done_lo w%0d k%0d", w, k), get_done(w1), 0);
      check($sformatf("diff_hold w%0d k%0d", w, k), get_diff(w1), prev_diff[i]);
      check($sformatf("bout_hold w%0d k%0d", w, k), get_bout(w1), prev_bout[i]);
      check($sformatf("zero_hold w%0d k%0d", w, k), get_zero(w1), prev_zero[i]);
      drive(w1, 1'b1, $urandom, $urandom);
      @(posedge clk); #1;
      drive(w1, 1'b0, $urandom, $urandom);
    end
    @(negedge clk);
    check($sformatf("done w%0d %0h-%0h m%0d", w, a, b, md), get_done(w1), 1);
    check($sformatf("busy_end w%0d", w), get_busy(w1), 0);
    check($sformatf("diff w%0d %0h-%0h m%0d", w, a, b, md), get_diff(w1), ed);
    check($sformatf("bout w%0d %0h-%0h m%0d", w, a, b, md), get_bout(w1), eb);
    check($sformatf("zero w%0d %0h-%0h m%0d", w, a, b, md), get_zero(w1), (ed == 0));
    prev_diff[i] = ed; prev_bout[i] = eb; prev_zero[i] = (ed == 0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("done_pulse w%0d", w), get_done(w1), 0);
    check($sformatf("idle_busy w%0d", w), get_busy(w1), 0);
    check($sformatf("diff_stable w%0d", w), get_diff(w1), ed);
  endtask

  // start held high with operands changing every cycle: each accepted
  // transaction occupies WIDTH RUN cycles plus one DONE cycle, then the
  // next edge in IDLE accepts again.
  task automatic held_start();
    int          p;
    int          ph;
    int          dones;
    logic [31:0] acc_a [3];
    logic [31:0] acc_b [3];
    logic [31:0] ra, rb, ed;
    logic        eb;
    p = int'(W8) + 2;
    dones = 0;
    for (int e = 0; e < 3 * p; e++) begin
      if (e >= 1) begin
        ph = (e - 1) % p;
        check($sformatf("held busy e%0d", e), if8.busy, (ph < int'(W8)));
        check($sformatf("held done e%0d", e), if8.done, (ph == int'(W8)));
        if (if8.done) dones++;
        if (ph == int'(W8)) begin
          model(W8, acc_a[(e - 1) / p], acc_b[(e - 1) / p], 1'b0, ed, eb);
          check($sformatf("held diff e%0d", e), if8.diff, ed);
          check($sformatf("held bout e%0d", e), if8.bout, eb);
          prev_diff[0] = ed; prev_bout[0] = eb; prev_zero[0] = (ed == 0);
        end
      end
      ra = $urandom; rb = $urandom;
      drive(1'b0, 1'b1, ra, rb);
      if (e % p == 0) begin
        acc_a[e / p] = ra;
        acc_b[e / p] = rb;
      end
      @(posedge clk);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 0, 0);
    check("held done count", dones, 3);
    check("held idle done", if8.done, 0);
  endtask

  // Reset asserted mid-operation: outputs clear at once, no done follows.
  task automatic reset_abort();
    drive(1'b0, 1'b1, $urandom, $urandom);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_abort busy", if8.busy, 0);
    check("rst_abort done", if8.done, 0);
    check("rst_abort diff", if8.diff, 0);
    check("rst_abort bout", if8.bout, 0);
    check("rst_abort zero", if8.zero, 0);
    for (int i = 0; i < 2; i++) begin
      prev_diff[i] = '0; prev_bout[i] = 1'b0; prev_zero[i] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < int'(W8) + 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst done k%0d", k), if8.done, 0);
      check($sformatf("post_rst busy k%0d", k), if8.busy, 0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
`ifdef SERIAL_SUB_ADDMODE_EN
    if8.mode = 1'b0;
    if1.mode = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      prev_diff[i] = '0; prev_bout[i] = 1'b0; prev_zero[i] = 1'b0;
    end
    #12;
    check("reset busy", if8.busy, 0);
    check("reset done", if8.done, 0);
    check("reset diff", if8.diff, 0);
    check("reset bout", if8.bout, 0);
    check("reset zero", if8.zero, 0);
    check("reset1 busy", if1.busy, 0);
    check("reset1 diff", if1.diff, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'h05, 32'h03, 1'b0);
    run_op(1'b0, 32'h03, 32'h05, 1'b0);
    run_op(1'b0, 32'h00, 32'h01, 1'b0);
    run_op(1'b0, 32'hA7, 32'hA7, 1'b0);
    for (int n = 0; n < 20; n++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 4) == 0) rb = ra;
      run_op(1'b0, ra, rb, 1'b0);
    end

    held_start();
    reset_abort();
    run_op(1'b0, 32'h3C, 32'h5A, 1'b0);

    run_op(1'b1, 32'h0, 32'h0, 1'b0);
    run_op(1'b1, 32'h0, 32'h1, 1'b0);
    run_op(1'b1, 32'h1, 32'h0, 1'b0);
    run_op(1'b1, 32'h1, 32'h1, 1'b0);
    for (int n = 0; n < 6; n++) run_op(1'b1, $urandom, $urandom, 1'b0);

`ifdef SERIAL_SUB_ADDMODE_EN
    run_op(1'b0, 32'hFF, 32'h01, 1'b1);
    run_op(1'b0, 32'h05, 32'h03, 1'b0);
    for (int n = 0; n < 10; n++) run_op(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
    run_op(1'b1, 32'h1, 32'h1, 1'b1);
    run_op(1'b1, 32'h0, 32'h1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
